// File: rtl/uart_rx_word_assembler.sv
// ---------------------------------------------------------------------------
// uart_rx_word_assembler
//
// Receive-side counterpart of the transmit byte shifter. Collects consecutive
// bytes strobed out of the UART receiver into one DATA_WIDTH-bit word,
// little-endian (first byte lands in the least significant byte). The
// completed word and a ready flag are presented to the memory-mapped register
// block; the core acknowledges through flag_rst. An inter-byte timeout drops
// a stalled partial word, and bytes arriving while a word is still unread are
// dropped and reported as an overrun.
//
// Parameters:
//   DATA_WIDTH  assembled word width, multiple of 8
//   TIMEOUT     max clk cycles allowed between bytes of one word
//
// Ports:
//   clk            in   1                     system clock
//   rst            in   1                     asynchronous reset, active-high
//   rx_byte        in   8                     received byte
//   rx_byte_valid  in   1                     byte-available level/pulse
//   flag_rst       in   1                     core ack: clears word_ready and
//                                             the sticky error flags
//   word_out       out  DATA_WIDTH            last completed word
//   word_ready     out  1                     word_out holds an unread word
//   byte_count     out  $clog2(BYTES)+1       bytes in current partial word
//   overrun        out  1                     sticky: byte dropped while ready
//   timeout_err    out  1                     sticky: partial word discarded
//
// All outputs come straight from registers; there is no combinational path
// from any input to any output.
// ---------------------------------------------------------------------------
module uart_rx_word_assembler #(
    parameter int DATA_WIDTH = 32,
    parameter int TIMEOUT    = 104160
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic [7:0]                      rx_byte,
    input  logic                            rx_byte_valid,
    input  logic                            flag_rst,
    output logic [DATA_WIDTH-1:0]           word_out,
    output logic                            word_ready,
    output logic [$clog2(DATA_WIDTH/8):0]   byte_count,
    output logic                            overrun,
    output logic                            timeout_err
);

    localparam int BYTES = DATA_WIDTH / 8;
    localparam int CNT_W = $clog2(BYTES) + 1;
    localparam int TMR_W = $clog2(TIMEOUT + 1);

    localparam logic [CNT_W-1:0] LAST_IDX    = CNT_W'(BYTES - 1);
    localparam logic [TMR_W-1:0] TIMEOUT_VAL = TMR_W'(TIMEOUT);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_COLLECT = 2'd1,
        S_READY   = 2'd2
    } state_t;

    state_t                  r_state;
    logic [DATA_WIDTH-1:0]   r_shift;
    logic [DATA_WIDTH-1:0]   r_word_out;
    logic                    r_word_ready;
    logic [CNT_W-1:0]        r_byte_count;
    logic                    r_overrun;
    logic                    r_timeout_err;
    logic [TMR_W-1:0]        r_timer;
    logic                    r_valid_prev;

    logic                    w_event;
    logic                    w_accept;
    logic                    w_last;
    logic [DATA_WIDTH-1:0]   w_shift_next;

    // One event per rising edge of rx_byte_valid, however long it stays high.
    assign w_event = rx_byte_valid & ~r_valid_prev;

    // A byte is taken whenever no unread word is pending, or when the core's
    // clear arrives in the same cycle as the byte (the clear wins).
    assign w_accept = w_event & ((r_state != S_READY) | flag_rst);

    // In IDLE and READY the count is 0, so the incoming byte is byte 0.
    assign w_last = (r_byte_count == LAST_IDX);

    // Shift register with the incoming byte merged into its slot. Starting a
    // new word clears stale bytes so a word never mixes two transfers.
    always_comb begin
        // NOTE: default every always_comb output first so no path leaves it
        // unassigned; otherwise synthesis infers a latch.
        w_shift_next = (r_byte_count == '0) ? '0 : r_shift;
        for (int k = 0; k < BYTES; k++) begin
            if (r_byte_count == CNT_W'(k)) begin
                w_shift_next[8*k +: 8] = rx_byte;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state       <= S_IDLE;
            r_shift       <= '0;
            r_word_out    <= '0;
            r_word_ready  <= 1'b0;
            r_byte_count  <= '0;
            r_overrun     <= 1'b0;
            r_timeout_err <= 1'b0;
            r_timer       <= '0;
            r_valid_prev  <= 1'b0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every
            // register here samples pre-edge values; later assignments in
            // this block override earlier ones (e.g. a flag_rst clear followed
            // by a same-cycle timeout set leaves timeout_err=1).
            r_valid_prev <= rx_byte_valid;

            // Core acknowledge clears the sticky flags in every state.
            if (flag_rst) begin
                r_overrun     <= 1'b0;
                r_timeout_err <= 1'b0;
            end

            if (r_state == S_READY && flag_rst) begin
                r_word_ready <= 1'b0;
            end

            if (w_accept) begin
                r_shift <= w_shift_next;
                r_timer <= '0;
                if (w_last) begin
                    // Word is published whole; never partially updated.
                    r_word_out   <= w_shift_next;
                    r_word_ready <= 1'b1;
                    r_byte_count <= '0;
                    r_state      <= S_READY;
                end else begin
                    r_byte_count <= r_byte_count + CNT_W'(1);
                    r_state      <= S_COLLECT;
                end
            end else begin
                unique case (r_state)
                    S_IDLE: begin
                        r_timer <= '0;
                    end
                    S_COLLECT: begin
                        if (r_timer == TIMEOUT_VAL) begin
                            // Stalled partial word: drop it, keep word_out.
                            r_byte_count  <= '0;
                            r_timer       <= '0;
                            r_timeout_err <= 1'b1;
                            r_state       <= S_IDLE;
                        end else begin
                            r_timer <= r_timer + TMR_W'(1);
                        end
                    end
                    S_READY: begin
                        if (flag_rst) begin
                            r_state <= S_IDLE;
                        end else if (w_event) begin
                            r_overrun <= 1'b1;
                        end
                    end
                    default: begin
                        r_state <= S_IDLE;
                    end
                endcase
            end
        end
    end

    assign word_out    = r_word_out;
    assign word_ready  = r_word_ready;
    assign byte_count  = r_byte_count;
    assign overrun     = r_overrun;
    assign timeout_err = r_timeout_err;

endmodule

// File: tb/tb_uart_rx_word_assembler.sv
// ---------------------------------------------------------------------------
// tb_uart_rx_word_assembler
//
// Directed bench for uart_rx_word_assembler with a short TIMEOUT. A queue-
// based reference model tracks the expected outputs and is compared every
// clock; literal expectations at key points pin the model itself.
// ---------------------------------------------------------------------------
module tb_uart_rx_word_assembler;

    localparam int DW    = 32;
    localparam int NB    = DW / 8;
    localparam int T_OUT = 100;

    logic                    clk;
    logic                    rst;
    logic [7:0]              rx_byte;
    logic                    rx_byte_valid;
    logic                    flag_rst;
    logic [DW-1:0]           word_out;
    logic                    word_ready;
    logic [$clog2(NB):0]     byte_count;
    logic                    overrun;
    logic                    timeout_err;

    int n_checks = 0;
    int n_errors = 0;

    uart_rx_word_assembler #(
        .DATA_WIDTH (DW),
        .TIMEOUT    (T_OUT)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .rx_byte       (rx_byte),
        .rx_byte_valid (rx_byte_valid),
        .flag_rst      (flag_rst),
        .word_out      (word_out),
        .word_ready    (word_ready),
        .byte_count    (byte_count),
        .overrun       (overrun),
        .timeout_err   (timeout_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    // Received bytes of the partial word, cycles since the last byte, and
    // the visible flags. Byte i of a word belongs at bits [8i+7:8i].
    byte unsigned m_q[$];
    int           m_idle;
    logic [DW-1:0] m_word;
    logic         m_ready;
    logic         m_ovr;
    logic         m_tmo;
    logic         m_prev;

    task automatic model_reset();
        m_q.delete();
        m_idle  = 0;
        m_word  = '0;
        m_ready = 1'b0;
        m_ovr   = 1'b0;
        m_tmo   = 1'b0;
        m_prev  = 1'b0;
    endtask

    task automatic model_step(input logic v, input logic [7:0] b, input logic f);
        logic ev;
        ev     = v && !m_prev;
        m_prev = v;
        if (f) begin
            m_ovr = 1'b0;
            m_tmo = 1'b0;
        end
        if (m_ready && !f) begin
            if (ev) m_ovr = 1'b1;
        end else begin
            m_ready = 1'b0;
            if (ev) begin
                m_q.push_back(b);
                m_idle = 0;
                if (m_q.size() == NB) begin
                    m_word = '0;
                    for (int i = 0; i < NB; i++) m_word[8*i +: 8] = m_q[i];
                    m_ready = 1'b1;
                    m_q.delete();
                end
            end else if (m_q.size() > 0) begin
                if (m_idle == T_OUT) begin
                    m_q.delete();
                    m_tmo  = 1'b1;
                    m_idle = 0;
                end else begin
                    m_idle++;
                end
            end
        end
    endtask

    initial begin
        model_reset();
        forever begin
            @(posedge clk or posedge rst);
            if (rst) begin
                model_reset();
            end else begin
                model_step(rx_byte_valid, rx_byte, flag_rst);
                #1;
                if (!rst) begin
                    check("m_word_out",    word_out,           m_word);
                    check("m_word_ready",  {31'd0, word_ready}, {31'd0, m_ready});
                    check("m_byte_count",  {29'd0, byte_count}, m_q.size());
                    check("m_overrun",     {31'd0, overrun},    {31'd0, m_ovr});
                    check("m_timeout_err", {31'd0, timeout_err}, {31'd0, m_tmo});
                end
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic send_byte(input logic [7:0] b, input int hold);
        @(negedge clk);
        rx_byte       = b;
        rx_byte_valid = 1'b1;
        repeat (hold) @(negedge clk);
        rx_byte_valid = 1'b0;
    endtask

    task automatic pulse_flag();
        @(negedge clk);
        flag_rst = 1'b1;
        @(negedge clk);
        flag_rst = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- directed sequence ----------------
    initial begin
        rst           = 1'b1;
        rx_byte       = 8'h00;
        rx_byte_valid = 1'b0;
        flag_rst      = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_word_out",    word_out, 32'h0);
        check("rst_word_ready",  {31'd0, word_ready}, 32'd0);
        check("rst_byte_count",  {29'd0, byte_count}, 32'd0);
        check("rst_overrun",     {31'd0, overrun}, 32'd0);
        check("rst_timeout_err", {31'd0, timeout_err}, 32'd0);
        rst = 1'b0;
        idle(2);

        // Basic assembly, valid held 3 cycles per byte.
        send_byte(8'h11, 3); check("bc_after_1", {29'd0, byte_count}, 32'd1);
        send_byte(8'h22, 3); check("bc_after_2", {29'd0, byte_count}, 32'd2);
        send_byte(8'h33, 3); check("bc_after_3", {29'd0, byte_count}, 32'd3);
        @(negedge clk);
        rx_byte       = 8'h44;
        rx_byte_valid = 1'b1;
        check("ready_before_edge", {31'd0, word_ready}, 32'd0);
        @(posedge clk); #1;
        check("ready_1clk_after", {31'd0, word_ready}, 32'd1);
        check("word_1", word_out, 32'h44332211);
        check("bc_after_4", {29'd0, byte_count}, 32'd0);
        repeat (3) @(negedge clk);
        rx_byte_valid = 1'b0;
        check("no_dup_bc", {29'd0, byte_count}, 32'd0);
        check("no_dup_ovr", {31'd0, overrun}, 32'd0);

        // Overrun while the word is unread.
        send_byte(8'hAA, 2);
        check("ovr_set", {31'd0, overrun}, 32'd1);
        check("ovr_word_kept", word_out, 32'h44332211);
        pulse_flag();
        check("ack_ready_clr", {31'd0, word_ready}, 32'd0);
        check("ack_ovr_clr", {31'd0, overrun}, 32'd0);

        // Timeout after two bytes.
        send_byte(8'h01, 1);
        send_byte(8'h02, 1);
        idle(100);
        check("pre_tmo_bc", {29'd0, byte_count}, 32'd2);
        check("pre_tmo_flag", {31'd0, timeout_err}, 32'd0);
        idle(1);
        check("tmo_bc", {29'd0, byte_count}, 32'd0);
        check("tmo_flag", {31'd0, timeout_err}, 32'd1);
        check("tmo_word_kept", word_out, 32'h44332211);
        send_byte(8'h05, 1);
        send_byte(8'h06, 2);
        send_byte(8'h07, 1);
        send_byte(8'h08, 1);
        check("word_2", word_out, 32'h08070605);
        check("word_2_ready", {31'd0, word_ready}, 32'd1);

        // Clear and new byte in the same cycle: clear wins, byte accepted.
        @(negedge clk);
        flag_rst      = 1'b1;
        rx_byte       = 8'h5A;
        rx_byte_valid = 1'b1;
        @(negedge clk);
        flag_rst = 1'b0;
        @(negedge clk);
        rx_byte_valid = 1'b0;
        check("same_cyc_ready", {31'd0, word_ready}, 32'd0);
        check("same_cyc_bc", {29'd0, byte_count}, 32'd1);
        check("same_cyc_ovr", {31'd0, overrun}, 32'd0);
        check("same_cyc_tmo", {31'd0, timeout_err}, 32'd0);
        send_byte(8'h5B, 1);
        send_byte(8'h5C, 1);
        send_byte(8'h5D, 1);
        check("word_3", word_out, 32'h5D5C5B5A);
        pulse_flag();

        // Asynchronous reset mid-word.
        send_byte(8'hD1, 2);
        send_byte(8'hD2, 2);
        check("pre_rst_bc", {29'd0, byte_count}, 32'd2);
        @(negedge clk);
        #2 rst = 1'b1;
        #1;
        check("arst_word_out", word_out, 32'h0);
        check("arst_bc", {29'd0, byte_count}, 32'd0);
        check("arst_ready", {31'd0, word_ready}, 32'd0);
        check("arst_flags", {30'd0, overrun, timeout_err}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        send_byte(8'hC1, 1);
        send_byte(8'hC2, 1);
        send_byte(8'hC3, 1);
        send_byte(8'hC4, 1);
        check("word_4", word_out, 32'hC4C3C2C1);
        pulse_flag();

        // Byte arrives on the exact cycle the timer hits TIMEOUT.
        send_byte(8'hE1, 1);
        idle(99);
        check("edge_bc_before", {29'd0, byte_count}, 32'd1);
        send_byte(8'hE2, 1);
        check("edge_bc_after", {29'd0, byte_count}, 32'd2);
        check("edge_no_tmo", {31'd0, timeout_err}, 32'd0);
        pulse_flag();
        check("flag_keeps_partial", {29'd0, byte_count}, 32'd2);
        send_byte(8'hE3, 1);
        send_byte(8'hE4, 1);
        check("word_5", word_out, 32'hE4E3E2E1);
        check("word_5_no_tmo", {31'd0, timeout_err}, 32'd0);
        idle(3);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/uart_rx_word_assembler.md
Name: uart_rx_word_assembler

Overview:
- Receive-side counterpart of the transmit byte shifter.
- Collects consecutive bytes strobed out of UART_RX (rx_register / enable_out_reg_w) into one 32-bit word, little-endian.
- Presents the word and a ready flag to the uart_in_out memory-mapped registers; the core clears the flag through uart_rx_flag_rst.
- Detects inter-byte timeout and overrun.

Parameters:
- DATA_WIDTH, 32, assembled word width; must be a multiple of 8.
- BYTES, DATA_WIDTH/8, bytes per word.
- TIMEOUT, 104160, max clk cycles between bytes of one word (2 byte times at 9600 baud, 50 MHz); counter width is $clog2(TIMEOUT+1).

Ports:
- clk  input  1  system clock
- rst  input  1  asynchronous reset, active-high
- rx_byte  input  8  received byte (rx_register from UART_RX)
- rx_byte_valid  input  1  byte-available level/pulse (enable_out_reg_w); may stay high several cycles
- flag_rst  input  1  core acknowledge; clears word_ready and the sticky error flags
- word_out  output  DATA_WIDTH  last completed word
- word_ready  output  1  word_out holds an unread complete word
- byte_count  output  $clog2(BYTES)+1  bytes collected in the current partial word
- overrun  output  1  sticky: a byte arrived while word_ready=1 and was dropped
- timeout_err  output  1  sticky: a partial word was discarded on timeout

Behaviour:
- Reset (async, rst=1): word_out=0, word_ready=0, byte_count=0, overrun=0, timeout_err=0, shift register=0, timer=0, valid-edge register=0, state=IDLE.
- Byte event: rising edge of rx_byte_valid, registered internally (prev register). One event per edge, regardless of high duration. rx_byte is sampled on the event cycle.
- States:
  - IDLE: byte_count=0.
  - COLLECT: 1..BYTES-1 bytes held.
  - READY: word_ready=1.
- IDLE + event: byte -> shift[7:0], byte_count=1, timer=0, go to COLLECT.
- COLLECT + event:
  - byte k (0-based) goes to shift[8k+7:8k]; byte_count increments; timer=0.
  - On byte BYTES-1: word_out gets the full word in the same clock (first byte in LSB), word_ready=1, byte_count=0, go to READY. Latency from last event edge to word_ready high: 1 clk.
- COLLECT, no event: timer increments. When timer==TIMEOUT, discard the partial word, byte_count=0, timeout_err=1, go to IDLE. word_out is unchanged.
- READY:
  - Event with flag_rst=0: byte dropped, overrun=1, word_out unchanged, stay in READY.
  - flag_rst=1 with no event: word_ready=0, overrun=0, timeout_err=0, go to IDLE.
  - flag_rst=1 and event in the same cycle: the clear wins. The byte is accepted as byte 0 of a new word (byte_count=1, COLLECT) and overrun is not set.
- flag_rst in IDLE/COLLECT: clears overrun and timeout_err only; does not disturb the partial word.
- Timeout and event in the same cycle: the event wins (byte accepted, timer=0).
- word_out is held between completions; it is never partially updated.
- Reset asserted mid-word: the partial word is lost and all outputs return to reset values immediately.
- No combinational path from inputs to outputs.

Test Plan:
- Reset, then events with bytes 0x11, 0x22, 0x33, 0x44 (valid held 3 cycles each) -> word_out=0x44332211, word_ready=1 one clk after the 4th edge, byte_count steps 1,2,3,0, no duplicate capture.
- With word_ready=1, send 0xAA -> overrun=1, word_out stays 0x44332211. Then pulse flag_rst -> word_ready=0, overrun=0.
- TIMEOUT=100 override: send 0x01, 0x02, then idle 101 cycles -> byte_count=0, timeout_err=1, word_out unchanged. Next 4 bytes 0x05..0x08 -> word_out=0x08070605.
- In READY, flag_rst and event 0x5A in the same cycle -> word_ready=0, byte_count=1, overrun=0. Three more bytes 0x5B, 0x5C, 0x5D -> word_out=0x5D5C5B5A.
- After 2 bytes, assert rst asynchronously between clock edges -> all outputs 0 immediately. A new 4-byte sequence assembles correctly from byte 0.
- Event arrives exactly on the cycle timer would reach TIMEOUT -> byte accepted, no timeout_err.
